// File: rtl/run_limit_serializer.sv
// Run-length-limited transmitter: shifts WIDTH-bit words out MSB-first and
// inserts a complemented stuff bit after every RUN identical line bits.
//
// Ports:
//   clk, nRESET          rising-edge clock, async active-low reset
//   load_valid/ready     word handshake; data_in sampled on acceptance
//   ser_out, ser_valid   serial line bit and its qualifier
//   stuff                current ser_out bit is an inserted stuff bit
//   done                 pulse on the final bit of a frame

module run_limit_serializer #(
    parameter int WIDTH = 8,
    parameter int RUN   = 3
) (
    input  logic             clk,
    input  logic             nRESET,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             stuff,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(RUN + 1);
    localparam logic [CW-1:0] WIDTH_V = CW'(WIDTH);
    localparam logic [RW-1:0] RUN_V   = RW'(RUN);

    // state names the kind of bit currently on the line
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        STUFF = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    bit_cnt;
    logic [RW-1:0]    run_cnt;
    logic             last_bit;

    logic [WIDTH-1:0] src_sh;
    logic [CW-1:0]    src_cnt;
    logic [RW-1:0]    src_run;
    logic             dbit;
    logic [RW-1:0]    d_run;
    logic [CW-1:0]    d_cnt;
    logic             d_done;
    logic             need_stuff;

    // Next data bit, taken from data_in when a word is being accepted
    // so the first bit reaches the line one cycle after acceptance.
    always_comb begin
        src_sh     = (state == IDLE) ? data_in : sh;
        src_cnt    = (state == IDLE) ? WIDTH_V : bit_cnt;
        src_run    = (state == IDLE) ? '0 : run_cnt;
        dbit       = src_sh[WIDTH-1];
        d_run      = (src_run != '0 && dbit == last_bit)
                     ? src_run + 1'b1 : RW'(1);
        d_cnt      = src_cnt - 1'b1;
        // last bit only if no trailing stuff bit will follow it
        d_done     = (d_run != RUN_V) && (d_cnt == '0);
        need_stuff = (state == SHIFT) && (run_cnt == RUN_V);
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state      <= IDLE;
            sh         <= '0;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            last_bit   <= 1'b0;
            load_ready <= 1'b1;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            stuff      <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (1'b1)
                (state == IDLE && load_valid),
                (state != IDLE && !need_stuff && bit_cnt != '0): begin
                    state      <= SHIFT;
                    sh         <= {src_sh[WIDTH-2:0], 1'b0};
                    bit_cnt    <= d_cnt;
                    run_cnt    <= d_run;
                    last_bit   <= dbit;
                    load_ready <= 1'b0;
                    ser_out    <= dbit;
                    ser_valid  <= 1'b1;
                    stuff      <= 1'b0;
                    done       <= d_done;
                end
                need_stuff: begin
                    state      <= STUFF;
                    run_cnt    <= RW'(1);
                    last_bit   <= ~last_bit;
                    load_ready <= 1'b0;
                    ser_out    <= ~last_bit;
                    ser_valid  <= 1'b1;
                    stuff      <= 1'b1;
                    done       <= (bit_cnt == '0);
                end
                default: begin
                    state      <= IDLE;
                    run_cnt    <= '0;
                    load_ready <= 1'b1;
                    ser_out    <= 1'b0;
                    ser_valid  <= 1'b0;
                    stuff      <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_limit_serializer.sv
// Scoreboard bench for run_limit_serializer (WIDTH=8, RUN=3).
// Expected line bits are queued at acceptance and popped per serial bit.

module tb_run_limit_serializer;

    localparam int W = 8;
    localparam int R = 3;

    logic         clk;
    logic         nRESET;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] data_in;
    logic         ser_out;
    logic         ser_valid;
    logic         stuff;
    logic         done;

    typedef struct packed {
        logic b;
        logic s;
        logic d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   frames = 0;
    int   exp_frames = 0;

    run_limit_serializer #(.WIDTH(W), .RUN(R)) dut (
        .clk        (clk),
        .nRESET     (nRESET),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data_in    (data_in),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .stuff      (stuff),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference line for one word, built bit by bit.
    task automatic model(input logic [W-1:0] w);
        exp_t t[$];
        int   run;
        logic last;
        exp_t e;
        run  = 0;
        last = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (run != 0 && w[i] == last) run++;
            else run = 1;
            last = w[i];
            t.push_back('{b: w[i], s: 1'b0, d: 1'b0});
            if (run == R) begin
                last = ~last;
                run  = 1;
                t.push_back('{b: last, s: 1'b1, d: 1'b0});
            end
        end
        e = t.pop_back();
        e.d = 1'b1;
        t.push_back(e);
        foreach (t[i]) q.push_back(t[i]);
        exp_frames++;
    endtask

    // Monitor: compare every serial bit against the scoreboard.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!nRESET) begin
                prev_done = 1'b0;
            end else begin
                if (prev_done) begin
                    chk("gap_valid", ser_valid, 0);
                    chk("gap_ready", load_ready, 1);
                end
                if (ser_valid) begin
                    chk("busy_ready", load_ready, 0);
                    if (q.size() == 0) begin
                        chk("extra_valid", ser_valid, 0);
                    end else begin
                        e = q.pop_front();
                        chk("ser_out", ser_out, e.b);
                        chk("stuff", stuff, e.s);
                        chk("done", done, e.d);
                        if (done) frames++;
                    end
                end else begin
                    chk("idle_stuff", stuff, 0);
                    chk("idle_done", done, 0);
                end
                prev_done = done && ser_valid;
            end
        end
    end

    task automatic send(input logic [W-1:0] w, input bit keep);
        int n;
        @(negedge clk);
        data_in    = w;
        load_valid = 1'b1;
        n = 0;
        while (!load_ready && n < 100) begin
            @(negedge clk);
            data_in = w;
            n++;
        end
        if (!load_ready) begin
            chk("ready_timeout", load_ready, 1);
            load_valid = 1'b0;
        end else begin
            model(w);
            @(posedge clk);
            #1;
            if (!keep) load_valid = 1'b0;
            data_in = ~w;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || !load_ready) && n < 100) begin
            @(negedge clk);
            data_in = W'($urandom);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRESET     = 1'b0;
        load_valid = 1'b1;
        data_in    = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", load_ready, 1);
            chk("rst_valid", ser_valid, 0);
            chk("rst_stuff", stuff, 0);
            chk("rst_done", done, 0);
            chk("rst_out", ser_out, 0);
        end
        load_valid = 1'b0;
        nRESET     = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", ser_valid, 0);

        send(8'hA5, 0); drain();
        send(8'h00, 0); drain();
        send(8'hFF, 0); drain();
        send(8'hF0, 0); drain();
        send(8'h07, 0); drain();

        send(8'h00, 1);
        send(8'hFF, 0);
        drain();

        send(8'h00, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_valid", ser_valid, 1);
        nRESET = 1'b0;
        #1;
        chk("async_valid", ser_valid, 0);
        chk("async_ready", load_ready, 1);
        chk("async_out", ser_out, 0);
        chk("async_stuff", stuff, 0);
        chk("async_done", done, 0);
        q.delete();
        exp_frames--;
        @(negedge clk);
        nRESET = 1'b1;
        @(negedge clk);
        chk("rel_valid", ser_valid, 0);
        send(8'h3C, 0); drain();

        for (int i = 0; i < 8; i++) begin
            send(W'($urandom), ($urandom_range(0, 1) == 1));
        end
        load_valid = 1'b0;
        drain();

        chk("queue_empty", q.size(), 0);
        chk("frames", frames, exp_frames);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/run_limit_serializer.md
# run_limit_serializer

Parallel-to-serial transmitter that shifts out WIDTH-bit words MSB-first and inserts a complemented stuff bit after every RUN identical consecutive bits, so the line never carries a run longer than RUN. It is the transmit end of the run-length-limited serial link. With default RUN=3 its output never triggers the team's 4-identical-bit run detector on the receive side. Sits between a word source (valid/ready) and the serial line.

## Interface
- WIDTH, 8, data word width; legal range ≥2.
- RUN, 3, maximum allowed run of identical bits; legal range ≥1.

- clk  input  1  clock, rising-edge.
- nRESET  input  1  reset, asynchronous, active-low.
- load_valid  input  1  source presents a word on data_in.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  word to transmit; sampled only on acceptance.
- ser_out  output  1  serial line bit.
- ser_valid  output  1  ser_out carries a frame bit (data or stuff).
- stuff  output  1  current ser_out bit is an inserted stuff bit.
- done  output  1  one-cycle pulse coinciding with the final bit of a frame.

## Operation
- All outputs are registered. Reset values: load_ready=1, ser_out=0, ser_valid=0, stuff=0, done=0. State=IDLE, counters cleared.
- Internal: shift register (WIDTH), bit_cnt (clog2(WIDTH+1)), run_cnt (clog2(RUN+1)), last_bit.
- FSM states: IDLE, SHIFT, STUFF.
- IDLE: load_ready=1, ser_valid=0, run_cnt=0. On load_valid&&load_ready: capture data_in, bit_cnt=WIDTH, and go to SHIFT.
- SHIFT: drive ser_out=data MSB, ser_valid=1, stuff=0. Shift left and decrement bit_cnt. Run update: if run_cnt≠0 and bit==last_bit, then run_cnt+1; otherwise run_cnt=1. Set last_bit=bit.
  - If the updated run_cnt==RUN, go to STUFF. This applies even after the last data bit.
  - Else if bit_cnt reaches 0, go to IDLE.
  - Else stay in SHIFT.
- STUFF: drive ser_out=~last_bit, ser_valid=1, stuff=1. Set run_cnt=1 and last_bit=~last_bit. Go to SHIFT if data bits remain, otherwise go to IDLE.
- done=1 exactly on the last emitted bit of the frame, whether that bit is data or stuff.
- Run tracking never spans frames: run_cnt is cleared in IDLE.
- load_valid while load_ready=0 is ignored. data_in changes after acceptance have no effect.
- nRESET low at any time: immediate return to reset values. The in-flight frame is discarded, with no partial bits after release.

## Timing
- Word accepted at edge k. The first bit is on ser_out during cycle k+1. load_ready drops at edge k.
- Frame length = WIDTH + number of stuff bits. ser_valid is continuously high for that many cycles, with no gaps.
- After the cycle carrying done, the next cycle is IDLE with load_ready=1. Minimum frame period = frame length + 1 cycle.
- A stuff bit always immediately follows the RUN-th identical bit. There is never a gap or reordering.
- Line guarantee: no run of identical bits longer than RUN within any frame.

## Test plan
- Reset: hold nRESET low with load_valid=1. Required: load_ready=1, ser_valid=0, stuff=0, done=0, ser_out=0, and no acceptance. Release, then accept 0xA5. Required: 8 cycles of 1,0,1,0,0,1,0,1; stuff never set; done on the 8th bit.
- 0x00: required line 0,0,0,1,0,0,0,1,0,0 (10 cycles). stuff=1 on cycles 4 and 8. done on cycle 10.
- 0xFF: required line 1,1,1,0,1,1,1,0,1,1. 0xF0: required line 1,1,1,0,1,0,0,0,1,0, with stuff on cycles 4 and 9.
- Trailing stuff, 0x07: required line 0,0,0,1,0,0,1,1,1,0. The last bit is stuff with done=1 in the same cycle. load_ready=1 the following cycle.
- Back-to-back with load_valid held high, 0x00 then 0xFF. Required: one IDLE cycle between frames. The second frame's run count starts fresh, so its line is 1,1,1,0,…. Toggling data_in mid-frame must not alter output.
- Pull nRESET low mid-frame during 0x00, on the 5th bit. Required: outputs return to reset values immediately. After release, the next accepted word transmits cleanly from its first bit.
